// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// One partial product per cycle through a single adder. Unsigned or
// two's-complement per operation, with valid/ready handshakes on both sides.
// Signed operands are turned into magnitudes at acceptance. The sign is
// applied once, on the final step.
module shift_add_multiplier #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     product_q, product_d;
   logic [CntW-1:0]   count_q, count_d;

   logic [WIDTH-1:0]  a_mag, b_mag;
   logic [PW-1:0]     addend, acc_sum;
   logic              last_step;

   // Operand magnitudes and the single shared adder
   always_comb begin
      a_mag     = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
      b_mag     = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
      addend    = mplier_q[count_q] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0;
      acc_sum   = acc_q + addend;
      last_step = (count_q == CntW'(WIDTH - 1));
   end

   // Next-state logic. Outputs decode from state only.
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      product_d = product_q;
      count_d   = count_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               mcand_d  = a_mag;
               mplier_d = b_mag;
               neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d    = '0;
               count_d  = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            acc_d   = acc_sum;
            count_d = count_q + 1'b1;
            if (last_step) begin
               // Final add and conditional negate land in the same cycle
               product_d = neg_q ? (~acc_sum + 1'b1) : acc_sum;
               state_d   = StDone;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplier_q  <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         product_q <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         count_q   <= count_d;
      end
   end

   // Output decode
   always_comb begin
      in_ready  = (state_q == StIdle);
      out_valid = (state_q == StDone);
      product   = product_q;
   end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Parametrised sequential multiplier, successor to the fixed 4x4 combinational array multiplier. Computes a WIDTH x WIDTH product one partial product per cycle with a single adder, selectable unsigned or two's-complement signed per operation. Valid/ready handshakes on input and output let it sit between producer and consumer stages in datapaths where area matters more than latency.

## Interface
- WIDTH, 8: operand width in bits, WIDTH >= 2; product is 2*WIDTH bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and mode presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = a, b and product are two's complement; 0 = unsigned.
- out_valid  output  1  product holds a completed result.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1, out_valid=0. On in_valid && in_ready: latch operands and signed_mode; clear accumulator; clear step counter; go to RUN.
- Operand latching:
  - Unsigned mode: magnitudes are a and b; neg=0.
  - Signed mode: magnitudes are |a| and |b| as WIDTH-bit unsigned values; neg = a[MSB] ^ b[MSB].
  - -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits; no overflow.
- RUN: in_ready=0, out_valid=0. Each cycle is one step. If multiplier-magnitude bit[count] is 1, add multiplicand-magnitude << count into the 2*WIDTH-bit accumulator. The add is unsigned, its width is 2*WIDTH, and it cannot overflow. count increments.
- RUN exit: after WIDTH steps, register product = neg ? (~acc + 1) : acc (mod 2^(2*WIDTH)), then go to DONE. The final step's add and the conditional negate happen in the same cycle.
- DONE: out_valid=1, in_ready=0. product is stable. On out_ready: go to IDLE.
- in_valid is ignored outside IDLE. a, b and signed_mode may change freely after acceptance.
- product keeps its last value after the output handshake and outside DONE. It changes only on RUN exit or reset.
- Zero operands take no shortcut: latency is always fixed.

## Timing
- Reset (async assert, any state, including mid-RUN or in DONE): state=IDLE, in_ready=1, out_valid=0, product=0, accumulator=0, count=0. Any in-flight operation is discarded.
- Reset deassertion is synchronised externally. The first acceptance can occur on the first clk edge with rst low.
- Acceptance edge E0 enters RUN. Steps occur on edges E0+1 .. E0+WIDTH.
- out_valid rises after edge E0+WIDTH, so latency is WIDTH cycles from acceptance to out_valid.
- Output handshake on edge E1 (out_valid && out_ready) returns to IDLE. in_ready is 1 in the following cycle.
- Maximum throughput is one result per WIDTH+2 cycles (RUN, DONE, IDLE). There is no accept during DONE.
- If out_ready is held high, DONE lasts exactly one cycle.
- If out_ready is low, DONE holds indefinitely with product and out_valid stable.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Test plan
- Unsigned, WIDTH=8, a=13, b=11, out_ready=1. Required: product=0x008F, out_valid high exactly 8 cycles after acceptance, in_ready low for 9 cycles (8 RUN + 1 DONE).
- Unsigned extremes: 0xFF*0xFF gives 0xFE01; 0x00*0xFF gives 0x0000 with unchanged latency.
- Signed corners:
  - -1*-1 (0xFF,0xFF) gives 0x0001.
  - -128*-128 gives 0x4000.
  - -128*127 gives 0xC080.
  - 5*-3 gives 0xFFF1.
- Backpressure: hold out_ready=0 for 20 cycles in DONE while toggling in_valid, a and b. Required: product stable, out_valid=1, in_ready=0, no new acceptance. After out_ready=1 for one cycle, return to IDLE.
- Async reset asserted mid-RUN (step 4) and, separately, in DONE. Required: outputs go to reset values immediately without a clock edge, product=0, and the next operation is correct.
- Randomised: 10k operations with random mode, operands, in_valid and out_ready gaps, for WIDTH=4, 8 and 16. Check against a reference model and check the fixed latency on every operation.
